fetch: RTL and testbench



---
 rtl/fetch.sv | 43 ++++
 tb/tb_fetch.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: fixed 256 x 15 program ROM with a registered read port.
// PROM_OUT takes ROM[P_COUNT] on each rising CLK_FT edge; RESET_N clears it asynchronously.
module fetch (
    input  logic        CLK_FT,
    input  logic        RESET_N,
    input  logic [7:0]  P_COUNT,
    output logic [14:0] PROM_OUT
);

    logic [14:0] rom_word;

    // Sum 1..10, storing each partial sum to address 64; everything past 14 is mov r0,r0.
    always_comb begin
        rom_word = '0;
        case (P_COUNT)
            8'd0:    rom_word = 15'h4800;  // ldh r0,0
            8'd1:    rom_word = 15'h4000;  // ldl r0,0
            8'd2:    rom_word = 15'h4900;  // ldh r1,0
            8'd3:    rom_word = 15'h4101;  // ldl r1,1
            8'd4:    rom_word = 15'h4A00;  // ldh r2,0
            8'd5:    rom_word = 15'h4200;  // ldl r2,0
            8'd6:    rom_word = 15'h4B00;  // ldh r3,0
            8'd7:    rom_word = 15'h430A;  // ldl r3,10
            8'd8:    rom_word = 15'h0A20;  // add r2,r1
            8'd9:    rom_word = 15'h0840;  // add r0,r2
            8'd10:   rom_word = 15'h7040;  // st r0,64
            8'd11:   rom_word = 15'h5260;  // cmp r2,r3
            8'd12:   rom_word = 15'h580E;  // je 14
            8'd13:   rom_word = 15'h6008;  // jmp 8
            8'd14:   rom_word = 15'h7800;  // hlt
            default: rom_word = '0;
        endcase
    end

    always_ff @(posedge CLK_FT or negedge RESET_N) begin
        if (!RESET_N) begin
            PROM_OUT <= '0;
        end else begin
            PROM_OUT <= rom_word;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: expected words are queued when P_COUNT is driven
// and popped when the registered output is sampled after the next rising edge.
module tb_fetch;

    logic        CLK_FT;
    logic        RESET_N;
    logic [7:0]  P_COUNT;
    logic [14:0] PROM_OUT;

    int unsigned checks;
    int unsigned passed;
    logic [14:0] exp_q [$];

    logic [14:0] prog [0:14] = '{
        15'h4800, 15'h4000, 15'h4900, 15'h4101, 15'h4A00,
        15'h4200, 15'h4B00, 15'h430A, 15'h0A20, 15'h0840,
        15'h7040, 15'h5260, 15'h580E, 15'h6008, 15'h7800
    };

    fetch dut (
        .CLK_FT   (CLK_FT),
        .RESET_N  (RESET_N),
        .P_COUNT  (P_COUNT),
        .PROM_OUT (PROM_OUT)
    );

    initial CLK_FT = 1'b0;
    always #10 CLK_FT = ~CLK_FT;

    function automatic logic [14:0] ref_word(input logic [7:0] pc);
        return (pc < 8'd15) ? prog[pc] : 15'h0000;
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] pc);
        @(negedge CLK_FT);
        P_COUNT = pc;
        exp_q.push_back(RESET_N ? ref_word(pc) : 15'h0000);
    endtask

    task automatic sample(input string tag);
        logic [14:0] exp;
        @(posedge CLK_FT);
        #1;
        exp = exp_q.pop_front();
        check(tag, PROM_OUT, exp);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks  = 0;
        passed  = 0;
        RESET_N = 1'b0;
        P_COUNT = 8'd3;
        #1;
        check("rst_init", PROM_OUT, 15'h0000);

        // Clock edges during reset are ignored.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(15'h0000);
            sample("rst_hold");
        end

        @(negedge CLK_FT);
        RESET_N = 1'b1;
        exp_q.push_back(ref_word(P_COUNT));
        sample("rst_release");

        for (int i = 0; i < 15; i++) begin
            drive(8'(i));
            sample("sweep");
        end

        drive(8'd15);  sample("unused15");
        drive(8'd100); sample("unused100");
        drive(8'd255); sample("unused255");
        drive(8'd0);   sample("wrap0");

        drive(8'd8);
        sample("reg8");
        @(negedge CLK_FT);
        check("fall_hold", PROM_OUT, ref_word(8'd8));
        P_COUNT = 8'd10;
        exp_q.push_back(ref_word(8'd10));
        #1;
        check("pc_change_hold", PROM_OUT, ref_word(8'd8));
        sample("reg10");
        @(negedge CLK_FT);
        #1;
        check("fall_hold10", PROM_OUT, ref_word(8'd10));

        drive(8'd11);
        sample("pre_async");
        #4;
        RESET_N = 1'b0;
        #1;
        check("async_clr", PROM_OUT, 15'h0000);
        exp_q.push_back(15'h0000);
        sample("async_hold");
        @(negedge CLK_FT);
        RESET_N = 1'b1;
        P_COUNT = 8'd13;
        exp_q.push_back(ref_word(8'd13));
        sample("async_release");

        drive(8'd14);
        @(posedge CLK_FT);
        RESET_N = 1'b0;
        #1;
        check("coincident_rst", PROM_OUT, 15'h0000);
        @(negedge CLK_FT);
        #1;
        check("coincident_hold", PROM_OUT, 15'h0000);
        RESET_N = 1'b1;
        exp_q.push_back(ref_word(P_COUNT));
        sample("coincident_release");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
